// File: rtl/access_pkg.sv
// Shared types and constants for the access control unit: FSM state encoding,
// word widths and the power-on credential table.
package access_pkg;

    localparam int ACCESS_WORD_W     = 16;
    localparam int STATE_W           = 3;
    localparam int NUM_DEFAULT_CREDS = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        GET_PW = 3'd1,
        CHECK  = 3'd2,
        CHANGE = 3'd3,
        GRANT  = 3'd4,
        DENY   = 3'd5,
        LOCKED = 3'd6
    } access_state_e;

    localparam logic [ACCESS_WORD_W-1:0] CRED_ID_DEFAULT [NUM_DEFAULT_CREDS] =
        '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    localparam logic [ACCESS_WORD_W-1:0] CRED_PW_DEFAULT [NUM_DEFAULT_CREDS] =
        '{16'h1234, 16'h2345, 16'h3456, 16'h4567};

    // Entries beyond the default table get ID 0, which can never match.
    function automatic logic [ACCESS_WORD_W-1:0] credIdDefault(input int idx);
        if (idx >= 0 && idx < NUM_DEFAULT_CREDS) return CRED_ID_DEFAULT[idx[1:0]];
        return '0;
    endfunction

    function automatic logic [ACCESS_WORD_W-1:0] credPwDefault(input int idx);
        if (idx >= 0 && idx < NUM_DEFAULT_CREDS) return CRED_PW_DEFAULT[idx[1:0]];
        return '0;
    endfunction

endpackage

// File: rtl/access_control_unit_if.sv
// Controller-facing bus of the access control unit. The controller owns the
// master modport; the checker owns the slave modport.
interface access_control_unit_if
    import access_pkg::*;
#(
    parameter int MAX_FAILS = 3
) ();

    localparam int FCW = $clog2(MAX_FAILS + 1);

    logic [ACCESS_WORD_W-1:0] userinput;
    logic                     load;
    logic                     pw_change;
    logic                     access_control_fb;
    logic                     denied;
    logic                     locked;
    logic [FCW-1:0]           fail_count;
    logic [STATE_W-1:0]       state_dbg;

    modport master (
        output userinput, load, pw_change,
        input  access_control_fb, denied, locked, fail_count, state_dbg
    );

    modport slave (
        input  userinput, load, pw_change,
        output access_control_fb, denied, locked, fail_count, state_dbg
    );

endinterface

// File: rtl/access_control_unit_credential_store.sv
// Credential table with parallel ID/password compare, lowest index winning.
// Build option ACCESS_PWCHANGE_EN adds a password write port; otherwise the table is constant.
module credential_store
    import access_pkg::*;
#(
    parameter int NUM_USERS = 4,
    parameter int IDXW      = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ACCESS_WORD_W-1:0] i_id,
    input  logic [ACCESS_WORD_W-1:0] i_pw,
`ifdef ACCESS_PWCHANGE_EN
    input  logic                     i_wrEn,
    input  logic [IDXW-1:0]          i_wrIdx,
    input  logic [ACCESS_WORD_W-1:0] i_wrData,
`endif
    output logic                     match,
    output logic [IDXW-1:0]          match_idx
);

    logic [ACCESS_WORD_W-1:0] w_idTable [NUM_USERS];
    logic [NUM_USERS-1:0]     w_hit;

`ifdef ACCESS_PWCHANGE_EN
    logic [ACCESS_WORD_W-1:0] r_pwTable [NUM_USERS];

    // Reset restores the defaults, discarding any password changed since.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_USERS; k++) r_pwTable[k] <= credPwDefault(k);
        end else if (i_wrEn) begin
            r_pwTable[i_wrIdx] <= i_wrData;
        end
    end
`else
    logic [ACCESS_WORD_W-1:0] r_pwTable [NUM_USERS];

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_constPw
        assign r_pwTable[g] = credPwDefault(g);
    end

    logic w_unusedClkRst;
    assign w_unusedClkRst = clk ^ rst;
`endif

    for (genvar g = 0; g < NUM_USERS; g++) begin : g_entry
        assign w_idTable[g] = credIdDefault(g);
        assign w_hit[g]     = (i_id != '0) && (w_idTable[g] == i_id) && (r_pwTable[g] == i_pw);
    end

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int k = NUM_USERS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                match     = 1'b1;
                match_idx = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/access_control_unit.sv
// Access control unit: captures user ID then password on load rising edges, checks them
// against the credential store, pulses grant/deny and locks out after repeated failures.
// Build option ACCESS_PWCHANGE_EN enables the in-place password change path.
module access_control_unit
    import access_pkg::*;
#(
    parameter int          NUM_USERS      = 4,
    parameter int          MAX_FAILS      = 3,
    parameter logic [31:0] LOCK_CYCLES    = 32'd50_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    access_control_unit_if.slave  bus
);

    localparam int FCW  = $clog2(MAX_FAILS + 1);
    localparam int IDXW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

    access_state_e            r_state;
    logic                     r_loadQ;
    logic                     r_loadArmed;
    logic [ACCESS_WORD_W-1:0] r_idReg;
    logic [ACCESS_WORD_W-1:0] r_pwReg;
    logic [31:0]              r_timeout;
    logic [31:0]              r_lockTimer;
    logic [FCW-1:0]           r_failCount;
    logic                     r_fb;
    logic                     r_denied;
    logic                     r_locked;

    logic                     w_loadRise;
    logic                     w_timeoutHit;
    logic [FCW-1:0]           w_nextFail;
    logic                     w_match;
    logic [IDXW-1:0]          w_matchIdx;

    // r_loadArmed blocks the false edge when load is already high as reset releases.
    assign w_loadRise   = bus.load & ~r_loadQ & r_loadArmed;
    assign w_timeoutHit = (r_timeout == TIMEOUT_CYCLES - 32'd1);
    assign w_nextFail   = r_failCount + FCW'(1);

`ifdef ACCESS_PWCHANGE_EN
    logic            r_chgReg;
    logic [IDXW-1:0] r_matchIdx;
    logic            w_wrEn;

    assign w_wrEn = (r_state == CHANGE) && w_loadRise;

    credential_store #(.NUM_USERS(NUM_USERS), .IDXW(IDXW)) u_store (
        .clk       (clk),
        .rst       (rst),
        .i_id      (r_idReg),
        .i_pw      (r_pwReg),
        .i_wrEn    (w_wrEn),
        .i_wrIdx   (r_matchIdx),
        .i_wrData  (bus.userinput),
        .match     (w_match),
        .match_idx (w_matchIdx)
    );
`else
    logic [IDXW:0] w_unusedBits;
    assign w_unusedBits = {bus.pw_change, w_matchIdx};

    credential_store #(.NUM_USERS(NUM_USERS), .IDXW(IDXW)) u_store (
        .clk       (clk),
        .rst       (rst),
        .i_id      (r_idReg),
        .i_pw      (r_pwReg),
        .match     (w_match),
        .match_idx (w_matchIdx)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_loadQ     <= 1'b0;
            r_loadArmed <= 1'b0;
            r_idReg     <= '0;
            r_pwReg     <= '0;
            r_timeout   <= '0;
            r_lockTimer <= '0;
            r_failCount <= '0;
            r_fb        <= 1'b0;
            r_denied    <= 1'b0;
            r_locked    <= 1'b0;
`ifdef ACCESS_PWCHANGE_EN
            r_chgReg    <= 1'b0;
            r_matchIdx  <= '0;
`endif
        end else begin
            r_loadQ  <= bus.load;
            r_fb     <= 1'b0;
            r_denied <= 1'b0;
            if (!bus.load) r_loadArmed <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_loadRise) begin
                        r_idReg   <= bus.userinput;
                        r_timeout <= '0;
                        r_state   <= GET_PW;
                    end
                end
                GET_PW: begin
                    if (w_loadRise) begin
                        r_pwReg <= bus.userinput;
`ifdef ACCESS_PWCHANGE_EN
                        r_chgReg <= bus.pw_change;
`endif
                        r_state <= CHECK;
                    end else if (w_timeoutHit) begin
                        r_state <= IDLE;
                    end else begin
                        r_timeout <= r_timeout + 32'd1;
                    end
                end
                // Outputs are set one cycle early so they line up with GRANT/DENY.
                CHECK: begin
                    if (!w_match) begin
                        r_denied <= 1'b1;
                        r_state  <= DENY;
                    end
`ifdef ACCESS_PWCHANGE_EN
                    else if (r_chgReg) begin
                        r_matchIdx <= w_matchIdx;
                        r_timeout  <= '0;
                        r_state    <= CHANGE;
                    end
`endif
                    else begin
                        r_fb    <= 1'b1;
                        r_state <= GRANT;
                    end
                end
`ifdef ACCESS_PWCHANGE_EN
                CHANGE: begin
                    if (w_loadRise) begin
                        r_fb    <= 1'b1;
                        r_state <= GRANT;
                    end else if (w_timeoutHit) begin
                        r_state <= IDLE;
                    end else begin
                        r_timeout <= r_timeout + 32'd1;
                    end
                end
`endif
                GRANT: begin
                    r_failCount <= '0;
                    r_state     <= IDLE;
                end
                DENY: begin
                    r_failCount <= w_nextFail;
                    if (w_nextFail == FCW'(MAX_FAILS)) begin
                        r_lockTimer <= LOCK_CYCLES - 32'd1;
                        r_locked    <= 1'b1;
                        r_state     <= LOCKED;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (r_lockTimer == '0) begin
                        r_locked    <= 1'b0;
                        r_failCount <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_lockTimer <= r_lockTimer - 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.access_control_fb = r_fb;
    assign bus.denied            = r_denied;
    assign bus.locked            = r_locked;
    assign bus.fail_count        = r_failCount;
    assign bus.state_dbg         = r_state;

endmodule
